// File: rtl/mul_div_sequencer.sv
// ---------------------------------------------------------------------------
// mul_div_sequencer
//
// Iterative RV32M multiply/divide unit. One shared shift-add / restoring
// shift-subtract datapath runs WIDTH iterations for every operation, so the
// latency is fixed regardless of operator or operand values.
//
// State table:
//   state | meaning
//   IDLE  | waiting for start; operands latched when start=1
//   PREP  | take magnitudes of signed operands, record result signs
//   CALC  | one iteration per cycle, counter 0..WIDTH-1
//   FIN   | done=1, Result valid; start=1 here chains straight into PREP
//
// Ports:
//   clk     in   clock, rising edge
//   reset   in   asynchronous active-high reset
//   start   in   request, sampled only in IDLE or FIN
//   flush   in   synchronous abort, wins over start
//   Funct3  in   op select (MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU)
//   SrcA    in   rs1 (multiplicand / dividend)
//   SrcB    in   rs2 (multiplier / divisor)
//   busy    out  high in PREP and CALC
//   done    out  one-cycle pulse in FIN
//   Result  out  registered result, held until the next done
// ---------------------------------------------------------------------------
module mul_div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       Funct3,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        CALC = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t state, state_next;

    logic latch_ops;
    logic last_iter;

    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   m_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CW-1:0]      cnt_q;
    logic               neg_q;
    logic               neg_r_q;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        latch_ops  = 1'b0;
        last_iter  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = PREP;
                    latch_ops  = 1'b1;
                end
            end
            PREP: begin
                busy       = 1'b1;
                state_next = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_next = FIN;
                    last_iter  = 1'b1;
                end
            end
            FIN: begin
                done = 1'b1;
                if (start) begin
                    state_next = PREP;
                    latch_ops  = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // A flush discards both a pending start and the final write-back.
        if (flush) begin
            state_next = IDLE;
            latch_ops  = 1'b0;
            last_iter  = 1'b0;
        end
    end

    // ------------------------------------------------------ operand prep
    logic             is_div;
    logic             a_signed;
    logic             b_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    always_comb begin
        is_div   = op_q[2];
        // Only MULHU, DIVU and REMU treat SrcA as unsigned.
        a_signed = (op_q != 3'b011) && (op_q != 3'b101) && (op_q != 3'b111);
        b_signed = (op_q == 3'b000) || (op_q == 3'b001) ||
                   (op_q == 3'b100) || (op_q == 3'b110);
        a_neg    = a_signed & a_q[WIDTH-1];
        b_neg    = b_signed & b_q[WIDTH-1];
        mag_a    = a_neg ? -a_q : a_q;
        mag_b    = b_neg ? -b_q : b_q;
    end

    // ---------------------------------------------------- shared datapath
    // Multiply: acc = {partial_hi, multiplier}, LSB-first add-and-shift-right.
    // Divide:   acc = {remainder, dividend/quotient}, restoring shift-left.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] acc_step;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff = rem_sh - {1'b0, m_q};
        if (!is_div) begin
            acc_step = {mul_sum, acc_q[WIDTH-1:1]};
        end else if (!div_diff[WIDTH]) begin
            acc_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_step = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
    end

    // Sign fix-up is applied to the value the last iteration produces, so
    // Result is written on the same edge that enters FIN.
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   res_next;

    always_comb begin
        prod = neg_q ? -acc_step : acc_step;
        quot = neg_q ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
        rem  = neg_r_q ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
        if (!is_div) begin
            res_next = (op_q[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
        end else begin
            res_next = op_q[1] ? rem : quot;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            neg_r_q <= 1'b0;
            Result  <= '0;
        end else begin
            if (latch_ops) begin
                op_q <= Funct3;
                a_q  <= SrcA;
                b_q  <= SrcB;
            end
            if (state == PREP) begin
                cnt_q <= '0;
                if (is_div) begin
                    acc_q   <= {{WIDTH{1'b0}}, mag_a};
                    m_q     <= mag_b;
                    // Divide by zero keeps the all-ones quotient unsigned.
                    neg_q   <= (a_neg ^ b_neg) & (b_q != '0);
                    neg_r_q <= a_neg;
                end else begin
                    acc_q   <= {{WIDTH{1'b0}}, mag_b};
                    m_q     <= mag_a;
                    neg_q   <= a_neg ^ b_neg;
                    neg_r_q <= 1'b0;
                end
            end else if (state == CALC) begin
                acc_q <= acc_step;
                cnt_q <= cnt_q + CW'(1);
            end
            if (last_iter) begin
                Result <= res_next;
            end
        end
    end

endmodule

// File: tb/tb_mul_div_sequencer.sv
module tb_mul_div_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        flush;
    logic [2:0]  Funct3;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        busy;
    logic        done;
    logic [31:0] Result;

    int total = 0;
    int bad   = 0;

    mul_div_sequencer #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .flush  (flush),
        .Funct3 (Funct3),
        .SrcA   (SrcA),
        .SrcB   (SrcB),
        .busy   (busy),
        .done   (done),
        .Result (Result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic following the RV32M rules.
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb, ua, ub, q;
        logic [63:0] p;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        p  = 64'h0;
        q  = 0;
        r  = 32'h0;
        case (op)
            3'd0: begin p = sa * sb; r = p[31:0];  end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: if (b == 32'h0) r = 32'hFFFF_FFFF;
                  else begin q = sa / sb; r = q[31:0]; end
            3'd5: if (b == 32'h0) r = 32'hFFFF_FFFF;
                  else begin q = ua / ub; r = q[31:0]; end
            3'd6: if (b == 32'h0) r = a;
                  else begin q = sa % sb; r = q[31:0]; end
            default: if (b == 32'h0) r = a;
                  else begin q = ua % ub; r = q[31:0]; end
        endcase
        return r;
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h1;
            4:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Called at #1 after an edge; cyc counts cycles since start was presented.
    task automatic wait_done(input int from_cyc, output int cyc, output int bcyc, output int both);
        cyc  = from_cyc;
        bcyc = 0;
        both = 0;
        for (int i = 0; i < 80; i++) begin
            if (busy) bcyc++;
            if (busy && done) both++;
            if (done) break;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string tag);
        int cyc, bcyc, both;
        @(negedge clk);
        start = 1'b1; Funct3 = op; SrcA = a; SrcB = b;
        @(posedge clk); #1;
        start = 1'b0; Funct3 = 3'($urandom); SrcA = $urandom; SrcB = $urandom;
        wait_done(1, cyc, bcyc, both);
        chk({tag, "_lat"}, 32'(cyc), 32'd34);
        chk({tag, "_busy_cycles"}, 32'(bcyc), 32'd33);
        chk({tag, "_busy_done_overlap"}, 32'(both), 32'd0);
        chk({tag, "_result"}, Result, exp);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_result_hold"}, Result, exp);
    endtask

    initial begin
        int cyc, bcyc, both, nd;
        logic [2:0]  op;
        logic [31:0] a, b, prev;

        reset = 1'b1; start = 1'b0; flush = 1'b0;
        Funct3 = 3'd0; SrcA = 32'h0; SrcB = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", Result, 32'h0);
        @(negedge clk); reset = 1'b0;

        run_op(3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu");
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh");
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, "div");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, "rem");
        run_op(3'd5, 32'd100,       32'd7,         32'd14,        "divu");
        run_op(3'd7, 32'd100,       32'd7,         32'd2,         "remu");
        run_op(3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, "divu_by0");
        run_op(3'd6, 32'd5,         32'd0,         32'd5,         "rem_by0");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         "rem_ovf");

        // Back-to-back with start held high; operands changed mid-op must not leak in.
        @(negedge clk);
        start = 1'b1; Funct3 = 3'd5; SrcA = 32'd1000; SrcB = 32'd7;
        @(posedge clk); #1;
        Funct3 = 3'd0; SrcA = 32'd12345; SrcB = 32'd678;
        wait_done(1, cyc, bcyc, both);
        chk("b2b_first_lat", 32'(cyc), 32'd34);
        chk("b2b_first_result", Result, ref_model(3'd5, 32'd1000, 32'd7));
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_restart_busy", 32'(busy), 32'd1);
        wait_done(1, cyc, bcyc, both);
        chk("b2b_second_lat", 32'(cyc), 32'd34);
        chk("b2b_second_result", Result, ref_model(3'd0, 32'd12345, 32'd678));
        @(posedge clk); #1;

        // Start pulse during CALC is ignored.
        @(negedge clk);
        start = 1'b1; Funct3 = 3'd6; SrcA = 32'hFFFF_FF9C; SrcB = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        start = 1'b1; Funct3 = 3'd0; SrcA = 32'd3; SrcB = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(11, cyc, bcyc, both);
        chk("calc_start_lat", 32'(cyc), 32'd34);
        chk("calc_start_result", Result, ref_model(3'd6, 32'hFFFF_FF9C, 32'd7));
        count_done(40, nd);
        chk("calc_start_extra_done", 32'(nd), 32'd0);
        prev = Result;

        // Flush at CALC counter 10.
        @(negedge clk);
        start = 1'b1; Funct3 = 3'd3; SrcA = 32'hFFFF_FFFF; SrcB = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_done", 32'(done), 32'd0);
        count_done(40, nd);
        chk("flush_no_done", 32'(nd), 32'd0);
        chk("flush_result_kept", Result, prev);

        // Flush in the last CALC cycle must not write Result.
        @(negedge clk);
        start = 1'b1; Funct3 = 3'd3; SrcA = 32'hFFFF_FFFF; SrcB = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (32) begin @(posedge clk); #1; end
        chk("flush_last_busy_before", 32'(busy), 32'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_last_done", 32'(done), 32'd0);
        chk("flush_last_result_kept", Result, prev);
        count_done(5, nd);
        chk("flush_last_no_done", 32'(nd), 32'd0);

        // Flush and start together in IDLE: start dropped.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; Funct3 = 3'd0; SrcA = 32'd9; SrcB = 32'd9;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("flush_start_busy", 32'(busy), 32'd0);
        count_done(40, nd);
        chk("flush_start_no_done", 32'(nd), 32'd0);

        // Reset mid-CALC.
        run_op(3'd5, 32'd100, 32'd7, 32'd14, "pre_reset");
        @(negedge clk);
        start = 1'b1; Funct3 = 3'd0; SrcA = 32'd55; SrcB = 32'd66;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) begin @(posedge clk); #1; end
        reset = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_result", Result, 32'h0);
        @(negedge clk); reset = 1'b0;
        count_done(3, nd);
        chk("midrst_no_done", 32'(nd), 32'd0);

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = rnd_operand();
            b  = rnd_operand();
            run_op(op, a, b, ref_model(op, a, b), $sformatf("rnd%0d_op%0d", i, op));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
